ika2151_timerctl: RTL
=====================

IKA2151_TIMERCTL -- requirements
Module: ika2151_timerctl

Interface
REQ-001 Parameter BUSY_CYCLES, default 32: number of phi1 cycles the busy flag stays high after a data write.
REQ-002 i_EMUCLK  in  1  emulator master clock; all state SHALL update on its rising edge only.
REQ-003 i_MRST_n  in  1  synchronous active-low reset, sampled on i_EMUCLK.
REQ-004 i_phi1_NCEN_n  in  1  active-low phi1 negative-edge clock enable; this is the register-apply and busy-count strobe.
REQ-005 i_CS_n, i_WR_n, i_RD_n  in  1 each  asynchronous CPU bus strobes, active-low.
REQ-006 i_A0  in  1  bus address select: 0 = address port, 1 = data port.
REQ-007 i_D  in  8  CPU write data.
REQ-008 o_D  out  8  read data {BUSY, 5'b0, TIMERB_FLAG, TIMERA_FLAG}; o_D_OE  out  1  high while ~i_CS_n & ~i_RD_n (synchronized).
REQ-009 i_TIMERA_FLAG, i_TIMERB_FLAG  in  1 each  status from the timer block.
REQ-010 o_CLKA1 (8), o_CLKA2 (2), o_CLKB (8), o_TEST (8)  out  timer period and test registers.
REQ-011 o_TIMERA_RUN, o_TIMERB_RUN, o_TIMERA_IRQ_EN, o_TIMERB_IRQ_EN, o_CSM  out  1 each  control bits.
REQ-012 o_TIMERA_FRST, o_TIMERB_FRST  out  1 each  flag-reset pulses.

Function
REQ-013 Write strobe wr = ~i_CS_n & ~i_WR_n SHALL pass through a 2-flop synchronizer on i_EMUCLK; a capture SHALL occur on the cycle the synchronized wr first goes 0->1.
REQ-014 On capture, i_A0 and i_D SHALL be latched into a pending slot (pend_valid=1); a capture while pend_valid is already 1 SHALL overwrite the slot (last write wins).
REQ-015 The pending slot SHALL be applied on the next i_EMUCLK edge with i_phi1_NCEN_n=0, which clears pend_valid; the apply edge is never the capture edge itself.
REQ-016 Apply with A0=0: address register <= D; no other state changes; busy unaffected.
REQ-017 Apply with A0=1: write D to the register selected by address: 0x01 -> TEST; 0x10 -> CLKA1; 0x11 -> CLKA2 = D[1:0]; 0x12 -> CLKB; 0x14 -> TIMERA_RUN=D[0], TIMERB_RUN=D[1], TIMERA_IRQ_EN=D[2], TIMERB_IRQ_EN=D[3], CSM=D[7]; any other address -> no register change.
REQ-018 0x14 write with D[4]=1 / D[5]=1 SHALL assert o_TIMERA_FRST / o_TIMERB_FRST for exactly one phi1 cycle (apply edge to next NCEN edge); FRST bits SHALL NOT be stored.
REQ-019 Every A0=1 apply, to any address including unmapped ones, SHALL load busy counter with BUSY_CYCLES and set BUSY=1.
REQ-020 Busy counter SHALL decrement on each NCEN edge while nonzero (not on the loading edge); BUSY SHALL clear on the NCEN edge where it reaches 0, i.e. BUSY high for exactly BUSY_CYCLES phi1 cycles.
REQ-021 A data write while BUSY=1 SHALL still be applied and SHALL reload the counter to BUSY_CYCLES.
REQ-022 o_D SHALL be registered every i_EMUCLK edge from current BUSY and the flag inputs; it SHALL be valid independent of o_D_OE.
REQ-023 Address register SHALL persist across data writes; consecutive data writes target the same address.
REQ-024 No i_EMUCLK-cycle combinational path SHALL exist from i_D/i_A0/strobes to any output.

Reset
REQ-025 While i_MRST_n=0 at an i_EMUCLK edge: address, TEST, CLKA1, CLKA2, CLKB, all RUN/IRQ_EN/CSM bits, FRST outputs, busy counter, BUSY, pend_valid, synchronizer flops, o_D_OE SHALL be 0; o_D SHALL be 8'h00.
REQ-026 Reset SHALL take effect regardless of i_phi1_NCEN_n; a pending write captured before reset SHALL be discarded.
REQ-027 After reset release, the first capture requires a fresh synchronized 0->1 of wr; a strobe held low through reset release counts as a new edge once the synchronizer fills.

Verification
REQ-028 Write A0=0 D=0x10 then A0=1 D=0xA5 -> o_CLKA1=0xA5 after second apply; BUSY=1 for exactly 32 phi1 cycles; o_D[7] follows.
REQ-029 Address 0x14, data 0x3F -> RUN A/B, IRQ_EN A/B =1; o_TIMERA_FRST and o_TIMERB_FRST high one phi1 cycle then 0; CSM=0.
REQ-030 Address 0x11 data 0xFF -> o_CLKA2=2'b11; address 0x13 data 0x55 -> no output register changes, BUSY still asserts.
REQ-031 Data write at busy count 5 -> counter reloads, BUSY stays high another 32 phi1 cycles.
REQ-032 Capture a write then assert i_MRST_n=0 before next NCEN -> no register changes; all outputs 0.
REQ-033 i_TIMERA_FLAG=1, i_TIMERB_FLAG=0, idle, CS_n=RD_n=0 -> o_D=8'h01, o_D_OE=1 within 3 i_EMUCLK cycles.

Source files
------------

// File: rtl/ika2151_timerctl.sv
// ika2151_timerctl: CPU-side register interface of the timer block.
//
// A CPU write arrives on asynchronous strobes. It passes through a 2-flop
// synchronizer, is held in a single pending slot, and is applied on the next
// phi1 negative-edge enable. Address-port writes (A0=0) load the address
// register. Data-port writes (A0=1) update the selected timer register and
// restart the busy counter. The status byte is re-registered on every
// emulator clock.
//
// Ports:
//   i_EMUCLK          master clock; all state updates on its rising edge
//   i_MRST_n          synchronous active-low reset
//   i_phi1_NCEN_n     active-low phi1 strobe for register apply and busy count
//   i_CS_n/WR_n/RD_n  asynchronous CPU bus strobes, active-low
//   i_A0, i_D         port select (0 = address, 1 = data) and write data
//   o_D, o_D_OE       status byte {BUSY, 5'b0, TIMERB_FLAG, TIMERA_FLAG} and read enable
//   i_TIMERx_FLAG     timer status flags
//   o_CLKA1/CLKA2/CLKB/TEST, run / irq-enable / CSM bits, FRST pulses
module ika2151_timerctl #(
    parameter int unsigned BUSY_CYCLES = 32
) (
    input  logic       i_EMUCLK,
    input  logic       i_MRST_n,
    input  logic       i_phi1_NCEN_n,
    input  logic       i_CS_n,
    input  logic       i_WR_n,
    input  logic       i_RD_n,
    input  logic       i_A0,
    input  logic [7:0] i_D,
    output logic [7:0] o_D,
    output logic       o_D_OE,
    input  logic       i_TIMERA_FLAG,
    input  logic       i_TIMERB_FLAG,
    output logic [7:0] o_CLKA1,
    output logic [1:0] o_CLKA2,
    output logic [7:0] o_CLKB,
    output logic [7:0] o_TEST,
    output logic       o_TIMERA_RUN,
    output logic       o_TIMERB_RUN,
    output logic       o_TIMERA_IRQ_EN,
    output logic       o_TIMERB_IRQ_EN,
    output logic       o_CSM,
    output logic       o_TIMERA_FRST,
    output logic       o_TIMERB_FRST
);

    localparam int unsigned CntW = $clog2(BUSY_CYCLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(BUSY_CYCLES);

    logic [1:0]      wr_sync;
    logic            wr_prev;
    logic [1:0]      rd_sync;
    logic            pend_valid;
    logic            pend_a0;
    logic [7:0]      pend_d;
    logic [7:0]      addr;
    logic [CntW-1:0] busy_cnt;
    logic            busy;

    logic wr_now, rd_now, capture, apply, data_apply;

    always_comb begin
        wr_now     = ~i_CS_n & ~i_WR_n;
        rd_now     = ~i_CS_n & ~i_RD_n;
        capture    = wr_sync[1] & ~wr_prev;
        // pend_valid is registered, so the capture edge can never be its own apply edge.
        apply      = pend_valid & ~i_phi1_NCEN_n;
        data_apply = apply & pend_a0;
    end

    assign o_D_OE = rd_sync[1];

    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            wr_sync         <= 2'b00;
            wr_prev         <= 1'b0;
            rd_sync         <= 2'b00;
            pend_valid      <= 1'b0;
            pend_a0         <= 1'b0;
            pend_d          <= 8'h00;
            addr            <= 8'h00;
            busy_cnt        <= '0;
            busy            <= 1'b0;
            o_D             <= 8'h00;
            o_CLKA1         <= 8'h00;
            o_CLKA2         <= 2'b00;
            o_CLKB          <= 8'h00;
            o_TEST          <= 8'h00;
            o_TIMERA_RUN    <= 1'b0;
            o_TIMERB_RUN    <= 1'b0;
            o_TIMERA_IRQ_EN <= 1'b0;
            o_TIMERB_IRQ_EN <= 1'b0;
            o_CSM           <= 1'b0;
            o_TIMERA_FRST   <= 1'b0;
            o_TIMERB_FRST   <= 1'b0;
        end else begin
            wr_sync <= {wr_sync[0], wr_now};
            wr_prev <= wr_sync[1];
            rd_sync <= {rd_sync[0], rd_now};
            o_D     <= {busy, 5'b00000, i_TIMERB_FLAG, i_TIMERA_FLAG};

            // FRST pulses last from their apply edge to the next phi1 strobe.
            if (!i_phi1_NCEN_n) begin
                o_TIMERA_FRST <= 1'b0;
                o_TIMERB_FRST <= 1'b0;
                if (busy_cnt != '0) begin
                    busy_cnt <= busy_cnt - 1'b1;
                    busy     <= (busy_cnt != CntW'(1));
                end
            end

            if (data_apply) begin
                busy_cnt <= CntLoad;
                busy     <= (BUSY_CYCLES != 0);
            end

            if (apply) begin
                pend_valid <= 1'b0;
                if (!pend_a0) begin
                    addr <= pend_d;
                end else begin
                    case (addr)
                        8'h01: o_TEST  <= pend_d;
                        8'h10: o_CLKA1 <= pend_d;
                        8'h11: o_CLKA2 <= pend_d[1:0];
                        8'h12: o_CLKB  <= pend_d;
                        8'h14: begin
                            o_TIMERA_RUN    <= pend_d[0];
                            o_TIMERB_RUN    <= pend_d[1];
                            o_TIMERA_IRQ_EN <= pend_d[2];
                            o_TIMERB_IRQ_EN <= pend_d[3];
                            o_TIMERA_FRST   <= pend_d[4];
                            o_TIMERB_FRST   <= pend_d[5];
                            o_CSM           <= pend_d[7];
                        end
                        default: ;
                    endcase
                end
            end

            // A capture on the apply edge refills the slot after it drains.
            if (capture) begin
                pend_valid <= 1'b1;
                pend_a0    <= i_A0;
                pend_d     <= i_D;
            end
        end
    end

endmodule
